// File: rtl/world_pkg.sv
// Shared constants for the world display: sprite codes, robot direction encoding,
// palette and default 640x480@60 timing.
package world_pkg;

  typedef enum logic [3:0] {
    SPR_WALL        = 4'd0,
    SPR_FREE_PATH   = 4'd1,
    SPR_TRASH_1     = 4'd3,
    SPR_TRASH_2     = 4'd4,
    SPR_TRASH_3     = 4'd5,
    SPR_BLACK_BLOCK = 4'd6
  } sprite_e;

  localparam int unsigned ROBOT_N_BIT = 1;
  localparam int unsigned ROBOT_S_BIT = 2;
  localparam int unsigned ROBOT_E_BIT = 3;
  localparam int unsigned ROBOT_W_BIT = 4;

  localparam logic [4:0] ROBOT_N = 5'(1 << ROBOT_N_BIT);
  localparam logic [4:0] ROBOT_S = 5'(1 << ROBOT_S_BIT);
  localparam logic [4:0] ROBOT_E = 5'(1 << ROBOT_E_BIT);
  localparam logic [4:0] ROBOT_W = 5'(1 << ROBOT_W_BIT);

  localparam logic [23:0] COL_WALL    = 24'h808080;
  localparam logic [23:0] COL_FREE    = 24'hFFFFFF;
  localparam logic [23:0] COL_TRASH_1 = 24'hC08040;
  localparam logic [23:0] COL_TRASH_2 = 24'h804000;
  localparam logic [23:0] COL_TRASH_3 = 24'h402000;
  localparam logic [23:0] COL_BLACK   = 24'h000000;
  localparam logic [23:0] COL_ERROR   = 24'hFF00FF;
  localparam logic [23:0] COL_CURSOR  = 24'h00FF00;
  localparam logic [23:0] COL_BODY    = 24'hFF0000;
  localparam logic [23:0] COL_HEAD    = 24'hFFFF00;

  localparam int unsigned TILE_BITS = 5;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  function automatic logic in_span(input logic [4:0] val, input logic [4:0] lo,
                                   input logic [4:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick phase plus horizontal/vertical counters with visible and sync decode.
module vga_timing
  import world_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input  logic       clock,
  input  logic       reset,
  output logic       tick,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       visible,
  output logic       hsync_n,
  output logic       vsync_n
);

  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] H_SS   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SE   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] V_SS   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SE   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  logic phase;

  always_ff @(posedge clock) begin
    if (reset) begin
      phase <= 1'b0;
      h     <= '0;
      v     <= '0;
    end else begin
      phase <= ~phase;
      if (phase) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
      end
    end
  end

  assign tick    = phase;
  assign visible = (h < H_VIS) && (v < V_VIS);
  assign hsync_n = !((h >= H_SS) && (h < H_SE));
  assign vsync_n = !((v >= V_SS) && (v < V_SE));

endmodule

// File: rtl/vga_world_renderer.sv
// Requests pixels from the world, registers the returned tile/robot data and
// paints tiles with robot and cursor overlays onto the VGA DAC two ticks later.
module vga_world_renderer
  import world_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input  logic       clock,
  input  logic       reset,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  input  logic [3:0] sprite,
  input  logic [1:0] robot_cursor_flags,
  input  logic [4:0] robot_type,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       frame_start
);

  localparam logic [9:0] X_MAX = 10'(H_VISIBLE - 1);
  localparam logic [9:0] Y_MAX = 10'(V_VISIBLE - 1);

  logic       tick, visible, hsync_n, vsync_n;
  logic [9:0] h, v;

  vga_timing #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .clock   (clock),
    .reset   (reset),
    .tick    (tick),
    .h       (h),
    .v       (v),
    .visible (visible),
    .hsync_n (hsync_n),
    .vsync_n (vsync_n)
  );

  // Blanking-region addresses are clamped so the world never sees an out-of-map request.
  assign pixel_x     = (h > X_MAX) ? X_MAX : h;
  assign pixel_y     = (v > Y_MAX) ? Y_MAX : v;
  assign vga_clk     = tick;
  assign frame_start = tick && !reset && (h == '0) && (v == '0);

  logic [3:0]           s1_sprite;
  logic [1:0]           s1_flags;
  logic [4:0]           s1_type;
  logic [TILE_BITS-1:0] s1_tx, s1_ty;
  logic                 s1_vis, s1_hs, s1_vs;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_sprite <= '0;
      s1_flags  <= '0;
      s1_type   <= '0;
      s1_tx     <= '0;
      s1_ty     <= '0;
      s1_vis    <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
    end else if (tick) begin
      s1_sprite <= sprite;
      s1_flags  <= robot_cursor_flags;
      s1_type   <= robot_type;
      s1_tx     <= h[TILE_BITS-1:0];
      s1_ty     <= v[TILE_BITS-1:0];
      s1_vis    <= visible;
      s1_hs     <= hsync_n;
      s1_vs     <= vsync_n;
    end
  end

  logic [23:0] tile_col, pix_col;
  logic        cursor_hit, body_hit, head_hit;

  always_comb begin
    tile_col = COL_ERROR;
    case (s1_sprite)
      SPR_WALL:        tile_col = COL_WALL;
      SPR_FREE_PATH:   tile_col = COL_FREE;
      SPR_TRASH_1:     tile_col = COL_TRASH_1;
      SPR_TRASH_2:     tile_col = COL_TRASH_2;
      SPR_TRASH_3:     tile_col = COL_TRASH_3;
      SPR_BLACK_BLOCK: tile_col = COL_BLACK;
      default:         tile_col = COL_ERROR;
    endcase

    cursor_hit = s1_flags[0] && ((s1_tx < 5'd2) || (s1_tx > 5'd29) ||
                                 (s1_ty < 5'd2) || (s1_ty > 5'd29));
    body_hit   = s1_flags[1] && in_span(s1_tx, 5'd8, 5'd23) && in_span(s1_ty, 5'd8, 5'd23);

    // A malformed direction code draws the body alone.
    head_hit = 1'b0;
    case (s1_type)
      ROBOT_N: head_hit = in_span(s1_tx, 5'd12, 5'd19) && in_span(s1_ty, 5'd4, 5'd7);
      ROBOT_S: head_hit = in_span(s1_tx, 5'd12, 5'd19) && in_span(s1_ty, 5'd24, 5'd27);
      ROBOT_E: head_hit = in_span(s1_tx, 5'd24, 5'd27) && in_span(s1_ty, 5'd12, 5'd19);
      ROBOT_W: head_hit = in_span(s1_tx, 5'd4, 5'd7)   && in_span(s1_ty, 5'd12, 5'd19);
      default: head_hit = 1'b0;
    endcase
    head_hit = head_hit && s1_flags[1];

    pix_col = '0;
    if (s1_vis) begin
      if (cursor_hit)    pix_col = COL_CURSOR;
      else if (head_hit) pix_col = COL_HEAD;
      else if (body_hit) pix_col = COL_BODY;
      else               pix_col = tile_col;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else if (tick) begin
      {vga_r, vga_g, vga_b} <= pix_col;
      vga_hs      <= s1_hs;
      vga_vs      <= s1_vs;
      vga_blank_n <= s1_vis;
    end
  end

endmodule

// File: tb/tb_vga_world_renderer.sv
// Scoreboard bench: a reduced-timing instance for pixel/sync/frame checks and a
// default-timing instance for 640x480 line timing and blanking clamp.
module tb_vga_world_renderer;

  localparam int SH_VIS = 128, SH_FP = 8, SH_SYNC = 16, SH_BP = 8;
  localparam int SV_VIS = 64,  SV_FP = 2, SV_SYNC = 2,  SV_BP = 4;
  localparam int S_LINE_PIX = SH_VIS + SH_FP + SH_SYNC + SH_BP;  // 160
  localparam int RESET_E = 47140;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  // reduced-timing DUT
  logic [9:0] px, py;
  logic [3:0] sprite;
  logic [1:0] flags;
  logic [4:0] rtype;
  logic       vclk, hs, vs, blank_n, fs;
  logic [7:0] r, g, b;

  // default-timing DUT
  logic [9:0] px_d, py_d;
  logic [3:0] sprite_d = 4'd0;
  logic [1:0] flags_d  = 2'd0;
  logic [4:0] rtype_d  = 5'd0;
  logic       vclk_d, hs_d, vs_d, blank_n_d, fs_d;
  logic [7:0] r_d, g_d, b_d;

  vga_world_renderer #(
    .H_VISIBLE(SH_VIS), .H_FRONT(SH_FP), .H_SYNC(SH_SYNC), .H_BACK(SH_BP),
    .V_VISIBLE(SV_VIS), .V_FRONT(SV_FP), .V_SYNC(SV_SYNC), .V_BACK(SV_BP)
  ) dut (
    .clock(clk), .reset(rst), .pixel_x(px), .pixel_y(py), .sprite(sprite),
    .robot_cursor_flags(flags), .robot_type(rtype), .vga_clk(vclk), .vga_hs(hs),
    .vga_vs(vs), .vga_blank_n(blank_n), .vga_r(r), .vga_g(g), .vga_b(b),
    .frame_start(fs)
  );

  vga_world_renderer dut_d (
    .clock(clk), .reset(rst), .pixel_x(px_d), .pixel_y(py_d), .sprite(sprite_d),
    .robot_cursor_flags(flags_d), .robot_type(rtype_d), .vga_clk(vclk_d), .vga_hs(hs_d),
    .vga_vs(vs_d), .vga_blank_n(blank_n_d), .vga_r(r_d), .vga_g(g_d), .vga_b(b_d),
    .frame_start(fs_d)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int e = 0;  // clock edges since reset released

  always @(posedge clk) begin
    if (rst) e = 0;
    else     e = e + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (edge %0d)", name, act, exp, e);
    end
  endtask

  typedef struct {
    int         x, y;
    logic [3:0] spr;
    logic [1:0] fl;
    logic [4:0] rt;
    logic [23:0] rgb;
    logic       blank;
    string      name;
  } vec_t;

  typedef struct {
    int          due;
    logic [24:0] exp;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  task automatic add(input int x, input int y, input logic [3:0] spr, input logic [1:0] fl,
                     input logic [4:0] rt, input logic [23:0] rgb, input logic blank,
                     input string name);
    vec_t vv;
    vv.x = x; vv.y = y; vv.spr = spr; vv.fl = fl; vv.rt = rt;
    vv.rgb = rgb; vv.blank = blank; vv.name = name;
    vecs.push_back(vv);
  endtask

  // world driver: presents table data for the requested pixel, pushes expectation
  always @(negedge clk) begin : drv
    int   p;
    exp_t it;
    if (rst) begin
      sprite = 4'd1; flags = 2'd0; rtype = 5'd0;
    end else if (e % 2 == 0) begin
      p = e / 2;
      sprite = 4'd1; flags = 2'd0; rtype = 5'd0;
      foreach (vecs[i]) begin
        if (vecs[i].y * S_LINE_PIX + vecs[i].x == p) begin
          sprite = vecs[i].spr; flags = vecs[i].fl; rtype = vecs[i].rt;
          check({"px ", vecs[i].name}, 64'(px), 64'((vecs[i].x < SH_VIS) ? vecs[i].x : SH_VIS - 1));
          check({"py ", vecs[i].name}, 64'(py), 64'((vecs[i].y < SV_VIS) ? vecs[i].y : SV_VIS - 1));
          it.due = e + 4;
          it.exp = {vecs[i].blank, vecs[i].rgb};
          it.name = vecs[i].name;
          exp_q.push_back(it);
        end
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin : mon
    exp_t it;
    if (!rst && exp_q.size() > 0 && e >= exp_q[0].due) begin
      it = exp_q.pop_front();
      check({"pix ", it.name}, 64'({blank_n, r, g, b}), 64'(it.exp));
    end
  end

  // sync / frame monitors
  int prev_hs[2] = '{1, 1}, prev_vs[2] = '{1, 1};
  int hfall_e[2], vfall_e[2], n_hs[2], n_vs[2], n_fs[2];
  int max_py = 0, max_px_d = 0;

  task automatic sync_mon(input int i, input logic h_s, input logic v_s, input logic f_s,
                          input int line_clk, input int hfall, input int hlow,
                          input int frame_clk, input int vfall, input int vlow);
    if (!rst) begin
      if (prev_hs[i] == 1 && h_s == 1'b0) begin
        n_hs[i]++; hfall_e[i] = e;
        check($sformatf("hs fall phase %0d", i), 64'((e >= hfall) ? (e - hfall) % line_clk : -1), 0);
      end
      if (prev_hs[i] == 0 && h_s == 1'b1)
        check($sformatf("hs low width %0d", i), 64'(e - hfall_e[i]), 64'(hlow));
      if (prev_vs[i] == 1 && v_s == 1'b0) begin
        n_vs[i]++; vfall_e[i] = e;
        check($sformatf("vs fall phase %0d", i), 64'((e >= vfall) ? (e - vfall) % frame_clk : -1), 0);
      end
      if (prev_vs[i] == 0 && v_s == 1'b1)
        check($sformatf("vs low width %0d", i), 64'(e - vfall_e[i]), 64'(vlow));
      if (f_s === 1'b1) begin
        n_fs[i]++;
        check($sformatf("frame_start phase %0d", i), 64'((e - 1) % frame_clk), 0);
      end
    end
    prev_hs[i] = int'(h_s);
    prev_vs[i] = int'(v_s);
  endtask

  always @(negedge clk) begin
    sync_mon(0, hs, vs, fs, 2 * S_LINE_PIX, 2 * (SH_VIS + SH_FP) + 4, 2 * SH_SYNC,
             2 * S_LINE_PIX * 72, 2 * S_LINE_PIX * (SV_VIS + SV_FP) + 4, 2 * S_LINE_PIX * SV_SYNC);
    sync_mon(1, hs_d, vs_d, fs_d, 1600, 2 * 656 + 4, 192, 840000, 2 * 800 * 490 + 4, 3200);
    if (!rst) begin
      if (int'(py) > max_py) max_py = int'(py);
      if (int'(px_d) > max_px_d) max_px_d = int'(px_d);
      if (e == 1400) begin
        check("dflt px at h700", 64'(px_d), 639);
        check("dflt py at h700", 64'(py_d), 0);
      end
      if (e == 1404) check("dflt blank at h700", 64'({blank_n_d, r_d, g_d, b_d}), 0);
      if (e == 4)    check("dflt wall (0,0)", 64'({blank_n_d, r_d, g_d, b_d}), 64'({1'b1, 24'h808080}));
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, " px"}, 64'(px), 0);
    check({tag, " py"}, 64'(py), 0);
    check({tag, " hs/vs"}, 64'({hs, vs}), 64'(2'b11));
    check({tag, " blank/rgb"}, 64'({blank_n, r, g, b}), 0);
    check({tag, " fs/vclk"}, 64'({fs, vclk}), 0);
    check({tag, " dflt px/hs"}, 64'({px_d, hs_d, fs_d}), 64'({10'd0, 1'b1, 1'b0}));
  endtask

  initial begin
    add(0,   0,  4'd0,  2'b00, 5'b00000, 24'h808080, 1'b1, "wall");
    add(1,   0,  4'd5,  2'b00, 5'b00000, 24'h402000, 1'b1, "trash_3");
    add(2,   0,  4'd15, 2'b00, 5'b00000, 24'hFF00FF, 1'b1, "err15");
    add(3,   0,  4'd2,  2'b00, 5'b00000, 24'hFF00FF, 1'b1, "err2");
    add(4,   0,  4'd1,  2'b00, 5'b00000, 24'hFFFFFF, 1'b1, "free");
    add(5,   0,  4'd3,  2'b00, 5'b00000, 24'hC08040, 1'b1, "trash_1");
    add(6,   0,  4'd4,  2'b00, 5'b00000, 24'h804000, 1'b1, "trash_2");
    add(7,   0,  4'd6,  2'b00, 5'b00000, 24'h000000, 1'b1, "black");
    add(47,  37, 4'd1,  2'b10, 5'b00010, 24'hFFFF00, 1'b1, "head N");
    add(47,  47, 4'd1,  2'b10, 5'b00010, 24'hFF0000, 1'b1, "body");
    add(34,  34, 4'd3,  2'b10, 5'b00010, 24'hC08040, 1'b1, "robot tile");
    add(79,  37, 4'd4,  2'b10, 5'b00110, 24'h804000, 1'b1, "bad type");
    add(44,  56, 4'd1,  2'b10, 5'b00100, 24'hFFFF00, 1'b1, "head S");
    add(59,  51, 4'd1,  2'b10, 5'b01000, 24'hFFFF00, 1'b1, "head E");
    add(36,  44, 4'd1,  2'b10, 5'b10000, 24'hFFFF00, 1'b1, "head W");
    add(23,  23, 4'd1,  2'b10, 5'b00010, 24'hFF0000, 1'b1, "body edge");
    add(24,  23, 4'd1,  2'b10, 5'b00010, 24'hFFFFFF, 1'b1, "past body");
    add(64,  44, 4'd1,  2'b11, 5'b01000, 24'h00FF00, 1'b1, "cursor tx0");
    add(95,  63, 4'd0,  2'b01, 5'b00000, 24'h00FF00, 1'b1, "cursor tx31");
    add(16,  16, 4'd6,  2'b01, 5'b00000, 24'h000000, 1'b1, "cursor inner");
    add(127, 63, 4'd5,  2'b00, 5'b00000, 24'h402000, 1'b1, "last visible");
    add(128, 10, 4'd0,  2'b00, 5'b00000, 24'h000000, 1'b0, "h blank");
    add(140, 5,  4'd0,  2'b11, 5'b00010, 24'h000000, 1'b0, "h blank flags");
    add(10,  64, 4'd0,  2'b00, 5'b00000, 24'h000000, 1'b0, "v blank");

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    @(posedge clk); #2 rst = 1'b0;

    while (e != RESET_E) @(negedge clk);
    check("pre-reset px", 64'(px), 50);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_checks("mid-line reset");
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("restart fs/vclk", 64'({fs, vclk}), 64'(2'b11));
    check("restart px", 64'(px), 0);
    @(negedge clk);
    check("restart fs low", 64'(fs), 0);
    check("restart px+1", 64'(px), 1);
    while (e != 700) @(negedge clk);

    check("scoreboard drained", 64'(exp_q.size()), 0);
    check("hs falls", 64'(n_hs[0]), 149);
    check("hs falls dflt", 64'(n_hs[1]), 29);
    check("vs falls", 64'(n_vs[0]), 2);
    check("frame_start count", 64'(n_fs[0]), 4);
    check("frame_start count dflt", 64'(n_fs[1]), 2);
    check("max pixel_y", 64'(max_py), 63);
    check("max pixel_x dflt", 64'(max_px_d), 639);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
